// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the alu_mdu execute unit.
//   alu_op_e    - 5-bit operation code: {1'b0, base code} for ALU ops,
//                 5'b10xxx for the multiply/divide group
//   mdu_state_e - control FSM states of alu_mdu
//   is_muldiv / is_div / op_a_signed / op_b_signed - op classification
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_XOR    = 5'b00011,
    OP_SLL    = 5'b00100,
    OP_SRL    = 5'b00101,
    OP_SUB    = 5'b00110,
    OP_SRA    = 5'b00111,
    OP_SLT    = 5'b01000,
    OP_SLTU   = 5'b01010,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  // 11xxx codes are undefined, so both top bits are needed here
  function automatic logic is_muldiv(alu_op_e op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_div(alu_op_e op);
    return is_muldiv(op) && op[2];
  endfunction

  // Operand A is signed for MULH, MULHSU, DIV, REM
  function automatic logic op_a_signed(alu_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is signed for MULH, DIV, REM
  function automatic logic op_b_signed(alu_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: shared iterative multiply / restoring-divide datapath.
//   start_i  - load operands and perform the first iteration this edge
//   op_i     - M-group op code (sampled on start_i)
//   a_i/b_i  - operands (sampled on start_i)
//   flush_i  - abandon the in-flight operation
//   done_o   - fixed-up result_o is valid this cycle (one-cycle pulse)
//   result_o - sign-corrected product half / quotient / remainder
// The start edge performs iteration 1, WIDTH-1 further edges complete the
// magnitude result, and done_o is raised for the fixup capture edge.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             start_i,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_src, acc_step, prod_fix;
  logic [WIDTH-1:0]   opnd_q, opnd_src, a_mag, b_mag, quo_fix, rem_fix;
  logic               div_q, hi_q, rem_q, neg_res_q, neg_rem_q;
  logic               div_src, a_neg, b_neg;
  logic [WIDTH:0]     rem_sh, diff, sum;

  assign a_neg = op_a_signed(op_i) && a_i[WIDTH-1];
  assign b_neg = op_b_signed(op_i) && b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // On start the step logic works on the freshly loaded operands so the
  // first iteration shares the accept edge.
  assign div_src  = start_i ? is_div(op_i) : div_q;
  // opnd holds the multiplicand for mul, the divisor for div
  assign opnd_src = start_i ? (is_div(op_i) ? b_mag : a_mag) : opnd_q;
  assign acc_src  = start_i ? {{WIDTH{1'b0}}, (is_div(op_i) ? a_mag : b_mag)} : acc_q;

  // acc layout: mul {partial product hi, multiplier bits still to consume}
  //             div {partial remainder, dividend bits -> quotient bits}
  always_comb begin
    acc_step = acc_src;
    rem_sh   = '0;
    diff     = '0;
    sum      = '0;
    if (div_src) begin
      rem_sh = {acc_src[2*WIDTH-1:WIDTH], acc_src[WIDTH-1]};
      diff   = rem_sh - {1'b0, opnd_src};
      if (!diff[WIDTH])
        acc_step = {diff[WIDTH-1:0], acc_src[WIDTH-2:0], 1'b1};
      else
        acc_step = {rem_sh[WIDTH-1:0], acc_src[WIDTH-2:0], 1'b0};
    end else begin
      sum      = {1'b0, acc_src[2*WIDTH-1:WIDTH]} + (acc_src[0] ? {1'b0, opnd_src} : '0);
      acc_step = {sum, acc_src[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      hi_q      <= 1'b0;
      rem_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q    <= 1'b1;
      cnt_q     <= CNT_W'(1);
      acc_q     <= acc_step;
      opnd_q    <= opnd_src;
      div_q     <= is_div(op_i);
      hi_q      <= (op_i != OP_MUL);
      rem_q     <= op_i[1];
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end else if (busy_q) begin
      if (cnt_q == CNT_W'(WIDTH)) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Quotient follows sign(a)^sign(b), remainder follows the dividend
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  assign done_o   = busy_q && (cnt_q == CNT_W'(WIDTH));
  assign result_o = div_q ? (rem_q ? rem_fix : quo_fix)
                          : (hi_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0]);

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle execute unit (base ALU ops + RV32M mul/div).
//   clk_i/rst_i        - clock, async active-high reset
//   flush_i            - synchronous abort of the in-flight op
//   valid_i/ready_o    - operand handshake (op_i, a_i, b_i)
//   valid_o/ready_i    - result handshake (result_o + flags)
//   zero_o/negative_o  - derived from the registered result
//   illegal_o          - op was not a defined code (qualified by valid_o)
// Base, illegal and special-case divides complete in one cycle; other
// mul/div ops run through muldiv_iter for WIDTH+1 cycles.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             negative_o,
  output logic             illegal_o
);

  localparam int               SH_W    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] alu_res, special_res, quick_res, iter_res;
  logic [SH_W-1:0]  shamt;
  logic             op_legal, div_zero, div_ovf, special;
  logic             go_iter, accept, handoff, iter_start, iter_done;

  // ---------------- base-op combinational path ----------------
  assign shamt = b_i[SH_W-1:0];

  always_comb begin
    alu_res  = '0;
    op_legal = 1'b1;
    case (op_i)
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_ADD:  alu_res = a_i + b_i;
      OP_XOR:  alu_res = a_i ^ b_i;
      OP_SLL:  alu_res = a_i << shamt;
      OP_SRL:  alu_res = a_i >> shamt;
      OP_SUB:  alu_res = a_i - b_i;
      OP_SRA:  alu_res = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:  alu_res = WIDTH'($signed(a_i) < $signed(b_i));
      OP_SLTU: alu_res = WIDTH'(a_i < b_i);
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = '0;
      default: op_legal = 1'b0;
    endcase
  end

  // Divides whose answer is known at accept skip the iterator
  assign div_zero = is_div(op_i) && (b_i == '0);
  assign div_ovf  = is_div(op_i) && op_b_signed(op_i) && (a_i == MIN_VAL) && (b_i == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    if (op_i[1]) special_res = div_zero ? a_i : '0;      // REM/REMU
    else         special_res = div_zero ? '1  : MIN_VAL; // DIV/DIVU
  end

  assign quick_res = special ? special_res : alu_res;
  assign go_iter   = is_muldiv(op_i) && !special;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept)       state_d = go_iter ? (op_i[2] ? S_DIV : S_MUL) : S_DONE;
        else if (handoff) state_d = S_IDLE;
      end
      S_MUL, S_DIV: if (iter_done) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // valid_o is high exactly in DONE, so a DONE cycle whose result is being
  // taken is as good as IDLE; this is what sustains one base op per cycle.
  always_comb begin
    ready_o    = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_i);
    accept     = valid_i && ready_o && !flush_i;
    handoff    = valid_o && ready_i;
    iter_start = accept && go_iter;
  end

  // ---------------- iterative datapath ----------------
  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .start_i  (iter_start),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

  // ---------------- result register ----------------
  // Flush only drops valid; the last result and flags stay visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      result_o  <= '0;
      illegal_o <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (iter_done) begin
      valid_o   <= 1'b1;
      result_o  <= iter_res;
      illegal_o <= 1'b0;
    end else if (accept) begin
      valid_o <= !go_iter;
      if (!go_iter) begin
        result_o  <= quick_res;
        illegal_o <= !op_legal;
      end
    end else if (handoff) begin
      valid_o <= 1'b0;
    end
  end

  assign zero_o     = (result_o == '0);
  assign negative_o = result_o[WIDTH-1];

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed + randomized check of alu_mdu (WIDTH=32 and WIDTH=8)
// against an arithmetic reference model working on 64-bit integers.
module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk, rst, flush, vld_in, rdy_out, vld_out, rdy_in;
  alu_op_e     op;
  logic [31:0] a, b, res;
  logic        zero, neg, ill;

  logic        flush8, vld_in8, rdy_out8, vld_out8, rdy_in8;
  alu_op_e     op8;
  logic [7:0]  a8, b8, res8;
  logic        zero8, neg8, ill8;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vld_in), .ready_o(rdy_out),
    .op_i(op), .a_i(a), .b_i(b), .valid_o(vld_out), .ready_i(rdy_in),
    .result_o(res), .zero_o(zero), .negative_o(neg), .illegal_o(ill)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush8), .valid_i(vld_in8), .ready_o(rdy_out8),
    .op_i(op8), .a_i(a8), .b_i(b8), .valid_o(vld_out8), .ready_i(rdy_in8),
    .result_o(res8), .zero_o(zero8), .negative_o(neg8), .illegal_o(ill8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: RV32M/ALU semantics for a w-bit datapath, plus expected latency.
  function automatic void ref_op(input logic [4:0] opc, input longint unsigned ai,
                                 input longint unsigned bi, input int w,
                                 output longint unsigned r, output bit il, output int lat);
    longint unsigned mask, ua, ub, minv;
    longint sa, sb, p;
    int sh;
    mask = (64'd1 << w) - 1;
    ua = ai & mask;
    ub = bi & mask;
    minv = 64'd1 << (w - 1);
    sa = ua[w-1] ? $signed(ua) - $signed(64'd1 << w) : $signed(ua);
    sb = ub[w-1] ? $signed(ub) - $signed(64'd1 << w) : $signed(ub);
    sh = int'(ub % longint'(w));
    r = 0; il = 0; lat = 1;
    case (opc)
      5'b00000: r = ua & ub;
      5'b00001: r = ua | ub;
      5'b00010: r = ua + ub;
      5'b00011: r = ua ^ ub;
      5'b00100: r = ua << sh;
      5'b00101: r = ua >> sh;
      5'b00110: r = ua - ub;
      5'b00111: r = sa >>> sh;
      5'b01000: r = (sa < sb) ? 1 : 0;
      5'b01010: r = (ua < ub) ? 1 : 0;
      5'b10000: begin r = ua * ub; lat = w + 1; end
      5'b10001: begin p = sa * sb; r = p >>> w; lat = w + 1; end
      5'b10010: begin p = sa * $signed(ub); r = p >>> w; lat = w + 1; end
      5'b10011: begin r = (ua * ub) >> w; lat = w + 1; end
      5'b10100: begin
        if (ub == 0) r = mask;
        else if (ua == minv && ub == mask) r = minv;
        else begin r = sa / sb; lat = w + 1; end
      end
      5'b10101: begin
        if (ub == 0) r = mask;
        else begin r = ua / ub; lat = w + 1; end
      end
      5'b10110: begin
        if (ub == 0) r = ua;
        else if (ua == minv && ub == mask) r = 0;
        else begin r = sa % sb; lat = w + 1; end
      end
      5'b10111: begin
        if (ub == 0) r = ua;
        else begin r = ua % ub; lat = w + 1; end
      end
      default: il = 1;
    endcase
    r = r & mask;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // One complete transaction on the 32-bit unit, optional result stall.
  task automatic run32(input logic [4:0] opc, input logic [31:0] ai, input logic [31:0] bi,
                       input int stall);
    longint unsigned er;
    bit ei;
    int el, lat;
    ref_op(opc, ai, bi, 32, er, ei, el);
    chk("ready_idle", rdy_out, 1);
    op = alu_op_e'(opc); a = ai; b = bi; vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    lat = 1;
    while (!vld_out && lat < 200) begin tick(); lat++; end
    chk("latency", lat, el);
    chk("result", res, er);
    chk("illegal", ill, ei);
    chk("zero", zero, (er == 0) ? 1 : 0);
    chk("negative", neg, er[31]);
    if (stall > 0) begin
      rdy_in = 1'b0;
      repeat (stall) tick();
      chk("hold_result", res, er);
      chk("hold_valid", vld_out, 1);
      chk("hold_ready", rdy_out, 0);
      rdy_in = 1'b1;
    end
    tick();
    chk("valid_drop", vld_out, 0);
  endtask

  task automatic run8(input logic [4:0] opc, input logic [7:0] ai, input logic [7:0] bi);
    longint unsigned er;
    bit ei;
    int el, lat;
    ref_op(opc, ai, bi, 8, er, ei, el);
    op8 = alu_op_e'(opc); a8 = ai; b8 = bi; vld_in8 = 1'b1;
    tick();
    vld_in8 = 1'b0;
    lat = 1;
    while (!vld_out8 && lat < 50) begin tick(); lat++; end
    chk("w8_latency", lat, el);
    chk("w8_result", res8, er);
    chk("w8_illegal", ill8, ei);
    tick();
  endtask

  initial begin
    int lat, hits;
    logic [31:0] saved;
    rst = 1'b1; flush = 1'b0; vld_in = 1'b0; rdy_in = 1'b1; op = OP_ADD; a = '0; b = '0;
    flush8 = 1'b0; vld_in8 = 1'b0; rdy_in8 = 1'b1; op8 = OP_ADD; a8 = '0; b8 = '0;
    #1;
    chk("rst_valid", vld_out, 0);
    chk("rst_result", res, 0);
    chk("rst_zero", zero, 1);
    chk("rst_neg", neg, 0);
    chk("rst_illegal", ill, 0);
    #20 rst = 1'b0;
    tick();
    chk("rst_ready", rdy_out, 1);

    // Back-to-back base ops: ADD overflow then SUB to zero
    op = OP_ADD; a = 32'h7FFF_FFFF; b = 32'h1; vld_in = 1'b1;
    tick();
    chk("b2b_valid1", vld_out, 1);
    chk("b2b_add", res, 32'h8000_0000);
    chk("b2b_neg", neg, 1);
    chk("b2b_ready", rdy_out, 1);
    op = OP_SUB; a = 32'd5; b = 32'd5;
    tick();
    vld_in = 1'b0;
    chk("b2b_valid2", vld_out, 1);
    chk("b2b_sub", res, 0);
    chk("b2b_zero", zero, 1);
    tick();
    chk("b2b_drop", vld_out, 0);

    // Multiply / divide directed cases
    run32(OP_MULH,   32'hFFFF_FFFF, 32'd2, 0);
    run32(OP_MULHU,  32'hFFFF_FFFF, 32'd2, 0);
    run32(OP_MUL,    32'hFFFF_FFFD, 32'd7, 0);
    run32(OP_DIV,    32'hFFFF_FFF9, 32'd2, 0);
    run32(OP_REM,    32'hFFFF_FFF9, 32'd2, 0);
    run32(OP_DIVU,   32'd7, 32'd0, 0);
    run32(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    run32(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    run32(OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run32(5'b11111,  32'h1234, 32'h5678, 0);
    run32(5'b01001,  32'h1234, 32'h5678, 0);

    // Back-pressure on DIVU 100/7, next op issued as ready_i releases
    rdy_in = 1'b0;
    op = OP_DIVU; a = 32'd100; b = 32'd7; vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    lat = 1;
    while (!vld_out && lat < 200) begin tick(); lat++; end
    chk("bp_latency", lat, 33);
    repeat (5) begin
      tick();
      chk("bp_result", res, 14);
      chk("bp_valid", vld_out, 1);
      chk("bp_ready", rdy_out, 0);
    end
    rdy_in = 1'b1;
    op = OP_ADD; a = 32'd2; b = 32'd3; vld_in = 1'b1;
    #1;
    chk("bp_release_ready", rdy_out, 1);
    tick();
    vld_in = 1'b0;
    chk("bp_next_valid", vld_out, 1);
    chk("bp_next_result", res, 5);
    tick();
    chk("bp_next_drop", vld_out, 0);

    // Flush during cycle 10 of a MUL
    saved = res;
    op = OP_MUL; a = 32'd1234; b = 32'd5678; vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", vld_out, 0);
    chk("flush_ready", rdy_out, 1);
    chk("flush_result_kept", res, saved);
    hits = 0;
    repeat (40) begin tick(); if (vld_out) hits++; end
    chk("flush_no_valid", hits, 0);
    run32(OP_MUL, 32'd1234, 32'd5678, 0);

    // Async reset mid-DIV
    run32(OP_ADD, 32'd3, 32'd4, 0);
    op = OP_DIV; a = 32'd1000; b = 32'd3; vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", vld_out, 0);
    chk("mid_rst_result", res, 0);
    chk("mid_rst_zero", zero, 1);
    chk("mid_rst_illegal", ill, 0);
    #3 rst = 1'b0;
    tick();
    chk("mid_rst_ready", rdy_out, 1);
    hits = 0;
    repeat (40) begin tick(); if (vld_out) hits++; end
    chk("mid_rst_no_valid", hits, 0);

    // Randomized ops with occasional result stalls
    for (int i = 0; i < 150; i++) begin
      run32(5'($urandom_range(0, 31)), pick32(), pick32(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end

    // WIDTH=8 instance
    run8(OP_MULHSU, 8'h80, 8'hFF);
    chk("w8_mulhsu_const", res8, 8'h80);
    for (int i = 0; i < 40; i++) begin
      run8(5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
